// File: rtl/paddle_game_ctrl.sv
// Frame-rate paddle/ball game controller for the 40x32 tile VGA demo.
// Owns paddle and ball tile positions; all state advances only on FRAME_TICK.
module paddle_game_ctrl #(
  parameter int unsigned PADDLE_W    = 6,
  parameter int unsigned BALL_DIV    = 4,
  parameter int unsigned PADDLE_DIV  = 2,
  parameter int unsigned OVER_FRAMES = 120
) (
  input  logic       CLK,
  input  logic       RST_IN,
  input  logic       LEFT,
  input  logic       RIGHT,
  input  logic       FRAME_TICK,
  output logic [5:0] PADDLE_X,
  output logic [5:0] BALL_X,
  output logic [4:0] BALL_Y,
  output logic [7:0] SCORE,
  output logic [1:0] STATE
);

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_OVER  = 2'd2,
    ST_BAD   = 2'd3
  } state_t;

  localparam int unsigned PDW = (PADDLE_DIV  > 1) ? $clog2(PADDLE_DIV)  : 1;
  localparam int unsigned BDW = (BALL_DIV    > 1) ? $clog2(BALL_DIV)    : 1;
  localparam int unsigned ODW = (OVER_FRAMES > 1) ? $clog2(OVER_FRAMES) : 1;

  localparam logic [PDW-1:0] PDIV_LAST = PDW'(PADDLE_DIV - 1);
  localparam logic [BDW-1:0] BDIV_LAST = BDW'(BALL_DIV - 1);
  localparam logic [ODW-1:0] OVER_LAST = ODW'(OVER_FRAMES - 1);

  localparam logic [5:0] PX_MIN = 6'd6;
  localparam logic [5:0] PX_MAX = 6'(40 - PADDLE_W);
  localparam logic [5:0] PX_RST = 6'd20;
  localparam logic [5:0] HALF   = 6'(PADDLE_W / 2);
  localparam logic [5:0] PW_M1  = 6'(PADDLE_W - 1);
  localparam logic [5:0] X_MIN  = 6'd6;
  localparam logic [5:0] X_MAX  = 6'd39;
  localparam logic [4:0] Y_TOP  = 5'd2;
  localparam logic [4:0] Y_PAD  = 5'd28;

  state_t         state_q, state_d;
  logic           l_meta_q, l_s_q, r_meta_q, r_s_q;
  logic [5:0]     px_q, px_d;
  logic [5:0]     bx_q, bx_d;
  logic [4:0]     by_q, by_d;
  logic           dx_q, dx_d;   // 1: moving right (+1)
  logic           dy_q, dy_d;   // 1: moving down  (+1)
  logic [7:0]     score_q, score_d;
  logic [PDW-1:0] pdiv_q, pdiv_d;
  logic [BDW-1:0] bdiv_q, bdiv_d;
  logic [ODW-1:0] ocnt_q, ocnt_d;

  logic           pstep, bstep, hit, y_hit, y_miss;
  logic [5:0]     px_mv, nx;
  logic [4:0]     ny;
  logic           ndx, ndy;

  always_ff @(posedge CLK) begin
    if (!RST_IN) begin
      l_meta_q <= 1'b0;
      l_s_q    <= 1'b0;
      r_meta_q <= 1'b0;
      r_s_q    <= 1'b0;
      state_q  <= ST_SERVE;
      px_q     <= PX_RST;
      bx_q     <= PX_RST + HALF;
      by_q     <= Y_PAD;
      dx_q     <= 1'b1;
      dy_q     <= 1'b0;
      score_q  <= '0;
      pdiv_q   <= '0;
      bdiv_q   <= '0;
      ocnt_q   <= '0;
    end else begin
      l_meta_q <= LEFT;
      l_s_q    <= l_meta_q;
      r_meta_q <= RIGHT;
      r_s_q    <= r_meta_q;
      state_q  <= state_d;
      px_q     <= px_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      score_q  <= score_d;
      pdiv_q   <= pdiv_d;
      bdiv_q   <= bdiv_d;
      ocnt_q   <= ocnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    bx_d    = bx_q;
    by_d    = by_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    score_d = score_q;
    pdiv_d  = pdiv_q;
    bdiv_d  = bdiv_q;
    ocnt_d  = ocnt_q;

    pstep = (pdiv_q == PDIV_LAST);
    bstep = (bdiv_q == BDIV_LAST);

    px_mv = px_q;
    if (pstep) begin
      if (l_s_q && !r_s_q && px_q != PX_MIN) begin
        px_mv = px_q - 6'd1;
      end else if (r_s_q && !l_s_q && px_q != PX_MAX) begin
        px_mv = px_q + 6'd1;
      end
    end

    // Hit window uses pre-tick paddle and pre-step ball column.
    hit = (bx_q >= px_q) && (bx_q <= px_q + PW_M1);

    ndx = dx_q;
    if (dx_q && bx_q == X_MAX) begin
      nx  = X_MAX - 6'd1;
      ndx = 1'b0;
    end else if (!dx_q && bx_q == X_MIN) begin
      nx  = X_MIN + 6'd1;
      ndx = 1'b1;
    end else begin
      nx = dx_q ? bx_q + 6'd1 : bx_q - 6'd1;
    end

    ndy    = dy_q;
    y_hit  = 1'b0;
    y_miss = 1'b0;
    if (!dy_q && by_q == Y_TOP) begin
      ny  = Y_TOP + 5'd1;
      ndy = 1'b1;
    end else if (dy_q && by_q == Y_PAD) begin
      if (hit) begin
        ny    = Y_PAD - 5'd1;
        ndy   = 1'b0;
        y_hit = 1'b1;
      end else begin
        ny     = Y_PAD + 5'd1;
        y_miss = 1'b1;
      end
    end else begin
      ny = dy_q ? by_q + 5'd1 : by_q - 5'd1;
    end

    if (FRAME_TICK) begin
      pdiv_d = pstep ? '0 : pdiv_q + 1'b1;
      case (state_q)
        ST_SERVE: begin
          px_d = px_mv;
          bx_d = px_mv + HALF;
          by_d = Y_PAD;
          if (l_s_q && r_s_q) begin
            state_d = ST_PLAY;
            dx_d    = 1'b1;
            dy_d    = 1'b0;
            score_d = '0;
            bdiv_d  = '0;
          end
        end
        ST_PLAY: begin
          px_d   = px_mv;
          bdiv_d = bstep ? '0 : bdiv_q + 1'b1;
          if (bstep) begin
            bx_d = nx;
            by_d = ny;
            dx_d = ndx;
            dy_d = ndy;
            if (y_hit && score_q != 8'hFF) begin
              score_d = score_q + 8'd1;
            end
            if (y_miss) begin
              state_d = ST_OVER;
              ocnt_d  = '0;
            end
          end
        end
        ST_OVER: begin
          if (ocnt_q == OVER_LAST) begin
            state_d = ST_SERVE;
            bx_d    = px_q + HALF;
            by_d    = Y_PAD;
            dx_d    = 1'b1;
            dy_d    = 1'b0;
          end else begin
            ocnt_d = ocnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_SERVE;
          bx_d    = px_q + HALF;
          by_d    = Y_PAD;
          dx_d    = 1'b1;
          dy_d    = 1'b0;
        end
      endcase
    end
  end

  assign PADDLE_X = px_q;
  assign BALL_X   = bx_q;
  assign BALL_Y   = by_q;
  assign SCORE    = score_q;
  assign STATE    = state_q;

endmodule

// File: doc/paddle_game_ctrl.md
Name: paddle_game_ctrl

Overview:
Frame-rate game controller for the VGA paddle/ball demo. Owns paddle and ball positions in the 40x32 tile map. Walls at XMAP=5/40 and YMAP=1/31; playfield interior X 6..39, Y 2..30. Advances state once per frame on FRAME_TICK. Outputs tile coordinates to the pixel mapper, which draws walls, paddle and ball.

Parameters:
PADDLE_W, 6, paddle width in tiles; paddle occupies row 29
BALL_DIV, 4, FRAME_TICKs per ball step (>=1)
PADDLE_DIV, 2, FRAME_TICKs per paddle step (>=1)
OVER_FRAMES, 120, FRAME_TICKs spent in OVER before re-serve (>=1)

Ports:
CLK  in  1  system clock; every flop on rising edge
RST_IN  in  1  synchronous active-low reset
LEFT  in  1  raw button, asynchronous
RIGHT  in  1  raw button, asynchronous
FRAME_TICK  in  1  one-CLK pulse per frame (start of vblank)
PADDLE_X  out  6  leftmost paddle tile, range 6..40-PADDLE_W
BALL_X  out  6  ball tile column
BALL_Y  out  5  ball tile row
SCORE  out  8  paddle hits this rally, saturates at 255
STATE  out  2  0=SERVE, 1=PLAY, 2=OVER

Behaviour:
- Reset (RST_IN=0 at a CLK edge): STATE=SERVE, PADDLE_X=20, BALL_X=PADDLE_X+PADDLE_W/2 (23 by default), BALL_Y=28, SCORE=0, dx=+1, dy=-1, all frame counters 0, synchronisers 0. Reset wins over every other event, including mid-rally.
- LEFT/RIGHT pass through 2-flop synchronisers (L_s, R_s). All logic uses only the synchronised values.
- All updates occur only in CLK cycles with FRAME_TICK=1. Outputs are registered and change on the following edge. Without FRAME_TICK, all state holds.
- Paddle divider counts ticks 0..PADDLE_DIV-1. Paddle step fires on the tick where the count equals PADDLE_DIV-1; the count then wraps to 0. The paddle moves in SERVE and PLAY only.
  - L_s&~R_s: PADDLE_X-1, saturating at 6.
  - R_s&~L_s: PADDLE_X+1, saturating at 40-PADDLE_W.
  - Both or neither: PADDLE_X holds.
- SERVE: ball rides the paddle. BALL_X=PADDLE_X_next+PADDLE_W/2, BALL_Y=28.
  - Launch: on a tick with L_s&R_s → PLAY; dx=+1, dy=-1; SCORE=0; ball divider cleared to 0.
- PLAY: ball divider counts like the paddle divider, with BALL_DIV. On a ball step:
  - X: if dx=+1 and BALL_X=39, set dx=-1 and X=38. If dx=-1 and BALL_X=6, set dx=+1 and X=7. Otherwise X+=dx.
  - Y: if dy=-1 and BALL_Y=2, set dy=+1 and Y=3.
  - Y: if dy=+1 and BALL_Y=28, test for a hit. A hit is PADDLE_X <= BALL_X <= PADDLE_X+PADDLE_W-1, using pre-tick PADDLE_X and pre-step BALL_X.
    - Hit: dy=-1, Y=27, SCORE+=1 (sat 255).
    - Miss: Y=29, X per the X rule, → OVER, over-counter=0.
  - Y: otherwise Y+=dy.
  - Corner case: X and Y reflections apply independently in the same step.
- OVER: ball and paddle frozen; SCORE holds; buttons ignored. Over-counter increments each tick. On the tick where it reaches OVER_FRAMES-1 → SERVE. That same tick sets the ball to the SERVE rule and dx=+1, dy=-1; PADDLE_X is kept.
- STATE value 3 is unreachable. If ever decoded, it returns to SERVE on the next tick.
- Width rules: all position arithmetic is done unsigned in 6 bits. Saturation and reflection bounds guarantee no wrap. BALL_Y is truncated to 5 bits after bound checks.

Test Plan:
- Reset/hold: RST_IN=0 for 2 cycles, then 1, with no FRAME_TICK for 100 cycles → PADDLE_X=20, BALL=(23,28), SCORE=0, STATE=0 throughout.
- Paddle saturation, PADDLE_DIV=1: hold LEFT, 20 ticks → PADDLE_X reaches 6 after 14 ticks and stays. Ball X tracks at PADDLE_X+3 (9). Hold RIGHT, 40 ticks → PADDLE_X=34, BALL_X=37. Both buttons from SERVE → launch, and PADDLE_X does not move that tick.
- Wall reflection, BALL_DIV=1: launch from PADDLE_X=20.
  - Ball path starts (24,27),(25,26)...
  - At Y=2 moving up, next step gives Y=3, dy=+1.
  - At X=39 moving right, next step gives X=38, dx=-1.
  - Checkpoint BALL_X/BALL_Y against a reference model every tick.
- Paddle hit: set up with the paddle under the ball (BALL_X=PADDLE_X+5 at Y=28, dy=+1) → next step Y=27, dy=-1, SCORE 0→1. Edge cell PADDLE_X+0 also hits; PADDLE_X+6 misses.
- Miss/over: ball at Y=28, dy=+1, paddle away → STATE=2, BALL_Y=29. With OVER_FRAMES=3 → STATE=0 exactly 3 ticks later, with SCORE retained until the next launch. Buttons held during OVER have no effect.
- Reset mid-rally: in PLAY with SCORE=5, assert RST_IN=0 coincident with FRAME_TICK=1 → next cycle shows reset values, STATE=0, SCORE=0.
